// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with PC, sequential fetch and in-order queue
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h00000000,
  parameter int          DEPTH     = 2,
  parameter logic [5:0]  HALT_OP   = 6'b111111,
  parameter logic [31:0] IDLE_ADDR = 32'hFFFFFFFC
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [31:0] o_Addr,
  input  logic [31:0] i_Instruction,
  output logic [31:0] o_Instr,
  output logic [31:0] o_PC,
  output logic        o_Valid,
  input  logic        i_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  output logic        o_Halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic full;
  logic pop;
  logic push;

  assign full = (count == FULL_CNT);
  assign pop  = o_Valid & i_Ready;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign push = (state == S_FETCH) && !i_Redirect && (!full || pop);

  assign o_Addr   = (state == S_FETCH) ? pc : IDLE_ADDR;
  assign o_Valid  = (count != '0);
  assign o_Instr  = o_Valid ? q_instr[rd_ptr] : 32'h0;
  assign o_PC     = o_Valid ? q_pc[rd_ptr]    : 32'h0;
  assign o_Halted = (state == S_HALT);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= S_IDLE;
      pc     <= BOOT_ADDR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= 32'h0;
        q_pc[i]    <= 32'h0;
      end
    end else if (i_Redirect) begin
      // Redirect wins over everything: flush, drop any pop, restart at target.
      state  <= S_FETCH;
      pc     <= i_Target & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == S_IDLE) begin
        state <= S_FETCH;
      end
      if (push) begin
        q_instr[wr_ptr] <= i_Instruction;
        q_pc[wr_ptr]    <= pc;
        wr_ptr          <= wr_ptr + PTR_ONE;
        pc              <= pc + 32'd4;
        if (i_Instruction[31:26] == HALT_OP) begin
          state <= S_HALT;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
